// File: rtl/mem_wait_cnt.sv
// Per-wavefront outstanding memory-op counters: +1 per LSU issue, -1 per SGPR/VGPR retire, clamped.
// Optional MEM_WAIT_ERR_EN builds a sticky under/overflow flag with the first offending wavefront id.
module mem_wait_cnt #(
    parameter int WF_PER_CU = 40,
    parameter int WFID_W    = 6,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lsu_valid,
    input  logic [WFID_W-1:0]    lsu_wfid,
    input  logic                 lsu_done,
    input  logic [WFID_W-1:0]    lsu_done_wfid,
    input  logic                 vgpr_lsu_wr_done,
    input  logic [WFID_W-1:0]    vgpr_lsu_wr_done_wfid,
    output logic [WF_PER_CU-1:0] mem_wait_arry,
    output logic [WF_PER_CU-1:0] mem_full_arry,
    output logic                 mem_err,
    output logic [WFID_W-1:0]    mem_err_wfid
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WF_PER_CU-1:0]            w_issue_hot;
    logic [WF_PER_CU-1:0]            w_sgpr_hot;
    logic [WF_PER_CU-1:0]            w_vgpr_hot;
    logic [WF_PER_CU-1:0]            w_unf;
    logic [WF_PER_CU-1:0]            w_ovf;
    logic [WF_PER_CU-1:0][CNT_W-1:0] r_cnt;
    logic [WF_PER_CU-1:0][CNT_W-1:0] w_cnt_nxt;

    genvar g;
    generate
        for (g = 0; g < WF_PER_CU; g++) begin : g_wf
            logic [CNT_W+1:0] w_sum;

            // ids >= WF_PER_CU never match any slot, so they decode to all-zero
            assign w_issue_hot[g] = lsu_valid        && (lsu_wfid              == WFID_W'(g));
            assign w_sgpr_hot[g]  = lsu_done         && (lsu_done_wfid         == WFID_W'(g));
            assign w_vgpr_hot[g]  = vgpr_lsu_wr_done && (vgpr_lsu_wr_done_wfid == WFID_W'(g));

            // two extra bits: range is -2 .. CNT_MAX+1, MSB is the sign
            assign w_sum = {2'b00, r_cnt[g]}
                         + (CNT_W+2)'(w_issue_hot[g])
                         - (CNT_W+2)'(w_sgpr_hot[g])
                         - (CNT_W+2)'(w_vgpr_hot[g]);

            assign w_unf[g] = w_sum[CNT_W+1];
            assign w_ovf[g] = ~w_sum[CNT_W+1] & w_sum[CNT_W];

            assign w_cnt_nxt[g] = w_unf[g] ? '0 :
                                  w_ovf[g] ? CNT_MAX : w_sum[CNT_W-1:0];

            assign mem_wait_arry[g] = |r_cnt[g];
            assign mem_full_arry[g] = &r_cnt[g];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

`ifdef MEM_WAIT_ERR_EN
    logic              w_err_any;
    logic [WFID_W-1:0] w_err_idx;
    logic              r_err;
    logic [WFID_W-1:0] r_err_wfid;

    assign w_err_any = |(w_unf | w_ovf);

    // scan downward so the lowest offending index wins
    always_comb begin
        w_err_idx = '0;
        for (int w = WF_PER_CU - 1; w >= 0; w--) begin
            if (w_unf[w] || w_ovf[w]) begin
                w_err_idx = WFID_W'(w);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_err_wfid <= '0;
        end else if (w_err_any && !r_err) begin
            r_err      <= 1'b1;
            r_err_wfid <= w_err_idx;
        end
    end

    assign mem_err      = r_err;
    assign mem_err_wfid = r_err_wfid;
`else
    assign mem_err      = 1'b0;
    assign mem_err_wfid = '0;
`endif

endmodule
